// File: rtl/int2flt_seq_if.sv
// Handshake bundle for int2flt_seq: integer input channel and packed float output channel.
interface int2flt_seq_if #(
  parameter int IW = 8,
  parameter int EW = 4
);
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [EW+IW:0] flt;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, flt, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, flt, out_valid
  );
endinterface

// File: rtl/int2flt_seq.sv
// Multi-cycle integer-to-float converter: captures an IW-bit integer, normalises one bit
// per cycle, and presents {sign, exp, frac} with valid/ready handshakes on both sides.
module int2flt_seq #(
  parameter int IW     = 8,
  parameter int EW     = 4,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          reset,
  int2flt_seq_if.slave  io,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EW-1:0] EXP_FULL = EW'(IW);
  localparam logic [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [IW-1:0] FRAC_ONE = IW'(1);

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic [IW-1:0]  frac_q, frac_d;
  logic           neg_s;
  logic [IW-1:0]  mag_s;

  // Sign/magnitude split; the most negative input wraps to 2^(IW-1) as unsigned.
  always_comb begin
    neg_s = 1'b0;
    mag_s = io.in_data;
    if ((SIGNED != 0) && io.in_data[IW-1]) begin
      neg_s = 1'b1;
      mag_s = ~io.in_data + FRAC_ONE;
    end else begin
      neg_s = 1'b0;
      mag_s = io.in_data;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          if (mag_s == {IW{1'b0}}) begin
            sign_d  = 1'b0;
            exp_d   = {EW{1'b0}};
            frac_d  = {IW{1'b0}};
            state_d = DONE;
          end else begin
            sign_d  = neg_s;
            exp_d   = EXP_FULL;
            frac_d  = mag_s;
            state_d = mag_s[IW-1] ? DONE : NORM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        frac_d  = frac_q << 1;
        exp_d   = exp_q - EXP_ONE;
        // The bit below the MSB becomes the leading one after this shift.
        if (frac_q[IW-2]) begin
          state_d = DONE;
        end else begin
          state_d = NORM;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= {EW{1'b0}};
      frac_q  <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign io.flt       = {sign_q, exp_q, frac_q};

endmodule
